// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed hex display driver. The segclk rising edge, detected in
// the clk domain, advances the scan. A per-frame snapshot of the inputs keeps
// multi-digit values from tearing.
module seg7_scan #(
    parameter int DIGITS     = 4,
    parameter bit ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  segclk,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp_n
);
    localparam int             IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0]  LAST = IW'(DIGITS - 1);

    // Hex to {g..a}, segment-on = 0.
    function automatic logic [6:0] hex_lo(input logic [3:0] n);
        case (n)
            4'h0: hex_lo = 7'h40;  4'h1: hex_lo = 7'h79;
            4'h2: hex_lo = 7'h24;  4'h3: hex_lo = 7'h30;
            4'h4: hex_lo = 7'h19;  4'h5: hex_lo = 7'h12;
            4'h6: hex_lo = 7'h02;  4'h7: hex_lo = 7'h78;
            4'h8: hex_lo = 7'h00;  4'h9: hex_lo = 7'h10;
            4'hA: hex_lo = 7'h08;  4'hB: hex_lo = 7'h03;
            4'hC: hex_lo = 7'h46;  4'hD: hex_lo = 7'h21;
            4'hE: hex_lo = 7'h06;  default: hex_lo = 7'h0E;
        endcase
    endfunction

    logic                  r_seg_d;
    logic [IW-1:0]         r_idx;
    logic                  r_started;
    logic [4*DIGITS-1:0]   r_sh_val;
    logic [DIGITS-1:0]     r_sh_dp;
    logic [DIGITS-1:0]     r_sh_blank;
    // Output registers hold active-high sense; polarity applied at the pins.
    logic [DIGITS-1:0]     r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;

    logic                  w_tick;
    logic                  w_wrap;
    logic [IW-1:0]         w_idx_nxt;
    logic [4*DIGITS-1:0]   w_val_nxt;
    logic [DIGITS-1:0]     w_dp_nxt;
    logic [DIGITS-1:0]     w_blank_nxt;
    logic                  w_started_nxt;
    logic [3:0]            w_nib;
    logic                  w_dp_bit;
    logic                  w_blank_bit;
    logic [DIGITS-1:0]     w_an_1h;
    logic                  w_on;

    assign w_tick        = segclk & ~r_seg_d;
    assign w_wrap        = (r_idx == LAST);
    assign w_idx_nxt     = w_wrap ? '0 : r_idx + IW'(1);
    // On a wrap the digit being displayed comes from the fresh snapshot.
    assign w_val_nxt     = w_wrap ? value : r_sh_val;
    assign w_dp_nxt      = w_wrap ? dp    : r_sh_dp;
    assign w_blank_nxt   = w_wrap ? blank : r_sh_blank;
    assign w_started_nxt = r_started | w_wrap;
    assign w_on          = w_started_nxt & ~w_blank_bit;

    // Select the nibble, dp, blank and anode for the digit about to be shown.
    always_comb begin
        w_nib       = '0;
        w_dp_bit    = 1'b0;
        w_blank_bit = 1'b0;
        w_an_1h     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx_nxt == IW'(i)) begin
                w_nib       = w_val_nxt[4*i +: 4];
                w_dp_bit    = w_dp_nxt[i];
                w_blank_bit = w_blank_nxt[i];
                w_an_1h[i]  = 1'b1;
            end
        end
    end

    // Edge detect, scan index, frame snapshot and registered digit outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_d    <= 1'b1;
            r_idx      <= LAST;
            r_started  <= 1'b0;
            r_sh_val   <= '0;
            r_sh_dp    <= '0;
            r_sh_blank <= '0;
            r_an       <= '0;
            r_seg      <= '0;
            r_dp       <= 1'b0;
        end else begin
            r_seg_d <= segclk;
            if (w_tick) begin
                r_idx      <= w_idx_nxt;
                r_started  <= w_started_nxt;
                r_sh_val   <= w_val_nxt;
                r_sh_dp    <= w_dp_nxt;
                r_sh_blank <= w_blank_nxt;
                r_an       <= w_on ? w_an_1h : '0;
                r_seg      <= w_on ? ~hex_lo(w_nib) : 7'h00;
                r_dp       <= w_on & w_dp_bit;
            end
        end
    end

    assign an   = ACTIVE_LOW ? ~r_an  : r_an;
    assign seg  = ACTIVE_LOW ? ~r_seg : r_seg;
    assign dp_n = ACTIVE_LOW ? ~r_dp  : r_dp;
endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: two instances (active-low and active-high) share stimulus;
// the active-high one must always show the bitwise inverse of the expected value.
module tb_seg7_scan;
    logic        clk = 1'b0;
    logic        rst, segclk;
    logic [15:0] value;
    logic [3:0]  dp, blank;
    logic [3:0]  an_l, an_h;
    logic [6:0]  seg_l, seg_h;
    logic        dpn_l, dpn_h;

    always #5 clk = ~clk;

    seg7_scan #(.DIGITS(4), .ACTIVE_LOW(1)) dut_l (
        .clk(clk), .rst(rst), .segclk(segclk), .value(value), .dp(dp),
        .blank(blank), .an(an_l), .seg(seg_l), .dp_n(dpn_l));
    seg7_scan #(.DIGITS(4), .ACTIVE_LOW(0)) dut_h (
        .clk(clk), .rst(rst), .segclk(segclk), .value(value), .dp(dp),
        .blank(blank), .an(an_h), .seg(seg_h), .dp_n(dpn_h));

    typedef struct {
        logic [15:0] value; logic [3:0] dp; logic [3:0] blank;
        logic [3:0]  an;    logic [6:0] seg; logic dpn;
    } vec_t;
    typedef struct {
        string name; logic [3:0] an; logic [6:0] seg; logic dpn;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    vec_t vt[20];
    int   n_chk = 0, n_pass = 0;

    task automatic cmp(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic push(input string n, input logic [3:0] a, input logic [6:0] s, input logic d);
        exp_t e;
        e.name = n; e.an = a; e.seg = s; e.dpn = d;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL sb_empty: got no expected entry want one");
            return;
        end
        e = sb.pop_front();
        last = e;
        cmp({e.name, "_al"}, {an_l, seg_l, dpn_l}, {e.an, e.seg, e.dpn});
        cmp({e.name, "_ah"}, {an_h, seg_h, dpn_h}, ~{e.an, e.seg, e.dpn});
    endtask

    task automatic check_dark(input string n);
        push(n, 4'hF, 7'h7F, 1'b1);
        check_pop();
    endtask

    // One segclk rise: check 1 clk after, then check it holds while segclk stays high.
    task automatic pulse();
        @(negedge clk) segclk = 1'b1;
        @(posedge clk); #1;
        check_pop();
        push({last.name, "_hold"}, last.an, last.seg, last.dpn);
        repeat (3) @(posedge clk);
        #1 check_pop();
        @(negedge clk) segclk = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        vt[0]  = '{16'h1234, 4'h0, 4'h0, 4'b1110, 7'h19, 1'b1};
        vt[1]  = '{16'h1234, 4'h0, 4'h0, 4'b1101, 7'h30, 1'b1};
        vt[2]  = '{16'hABCD, 4'h0, 4'h0, 4'b1011, 7'h24, 1'b1};
        vt[3]  = '{16'hABCD, 4'h0, 4'h0, 4'b0111, 7'h79, 1'b1};
        vt[4]  = '{16'hABCD, 4'h0, 4'h0, 4'b1110, 7'h21, 1'b1};
        vt[5]  = '{16'hABCD, 4'h0, 4'h0, 4'b1101, 7'h46, 1'b1};
        vt[6]  = '{16'hABCD, 4'h0, 4'h0, 4'b1011, 7'h03, 1'b1};
        vt[7]  = '{16'hABCD, 4'h0, 4'h0, 4'b0111, 7'h08, 1'b1};
        vt[8]  = '{16'hABCD, 4'b0100, 4'b1000, 4'b1110, 7'h21, 1'b1};
        vt[9]  = '{16'hABCD, 4'b0100, 4'b1000, 4'b1101, 7'h46, 1'b1};
        vt[10] = '{16'hABCD, 4'b0100, 4'b1000, 4'b1011, 7'h03, 1'b0};
        vt[11] = '{16'hABCD, 4'b0100, 4'b1000, 4'b1111, 7'h7F, 1'b1};
        vt[12] = '{16'h0F5E, 4'hF, 4'h0, 4'b1110, 7'h06, 1'b0};
        vt[13] = '{16'h0F5E, 4'hF, 4'h0, 4'b1101, 7'h12, 1'b0};
        vt[14] = '{16'h0F5E, 4'hF, 4'h0, 4'b1011, 7'h0E, 1'b0};
        vt[15] = '{16'h0F5E, 4'hF, 4'h0, 4'b0111, 7'h40, 1'b0};
        vt[16] = '{16'h6789, 4'h0, 4'h0, 4'b1110, 7'h10, 1'b1};
        vt[17] = '{16'h6789, 4'h0, 4'h0, 4'b1101, 7'h00, 1'b1};
        vt[18] = '{16'h6789, 4'h0, 4'h0, 4'b1011, 7'h78, 1'b1};
        vt[19] = '{16'h6789, 4'h0, 4'h0, 4'b0111, 7'h02, 1'b1};

        rst = 1'b1; segclk = 1'b0; value = '0; dp = '0; blank = '0;

        // Reset held, segclk low: dark throughout.
        for (int i = 0; i < 4; i++) begin
            repeat (25) @(posedge clk);
            #1 check_dark($sformatf("rst_dark%0d", i));
        end

        // Release with segclk already high: no tick.
        @(negedge clk) segclk = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_dark("rel_high");
        @(negedge clk) segclk = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_dark("rel_fall");

        // Table-driven scan vectors.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            value = vt[i].value; dp = vt[i].dp; blank = vt[i].blank;
            push($sformatf("vec%0d", i), vt[i].an, vt[i].seg, vt[i].dpn);
            pulse();
        end

        // Reset mid-frame at idx 2.
        @(negedge clk); value = 16'h1234; dp = '0; blank = '0;
        push("pre_d0", 4'b1110, 7'h19, 1'b1); pulse();
        push("pre_d1", 4'b1101, 7'h30, 1'b1); pulse();
        push("pre_d2", 4'b1011, 7'h24, 1'b1); pulse();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check_dark("mid_rst");
        cmp("mid_rst_idx", {10'b0, dut_l.r_idx}, 12'd3);
        @(negedge clk) begin rst = 1'b0; value = 16'h5678; end
        push("post_d0", 4'b1110, 7'h00, 1'b1); pulse();
        push("post_d1", 4'b1101, 7'h78, 1'b1); pulse();

        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Multiplexed 4-digit hex display driver for the board's 7-segment display.
- Sits directly downstream of the clock divider and consumes its 381.47 Hz segclk output as a digit-advance strobe.
- Runs entirely in the master clk domain. The segclk rising edge is detected in logic; segclk is never used as a clock.
- Latches a coherent snapshot of the displayed value once per scan frame, so multi-digit values never tear.

Parameters:
- DIGITS, 4: number of digits scanned. Legal range 1..8. The index width is clog2(DIGITS), minimum 1.
- ACTIVE_LOW, 1: 1 means an, seg and dp_n are asserted low (board default); 0 inverts all three output groups.

Ports:
- clk  input  1  master clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- segclk  input  1  scan-rate square wave from the clock divider, in the same clk domain.
- value  input  4*DIGITS  hex nibbles; nibble i = value[4i+3:4i], digit 0 is rightmost.
- dp  input  DIGITS  decimal point request per digit, 1 = lit.
- blank  input  DIGITS  per-digit blanking, 1 = digit dark.
- an  output  DIGITS  digit anode enables.
- seg  output  7  segments {g,f,e,d,c,b,a}.
- dp_n  output  1  decimal point segment.

Behaviour:
- Synchronous reset, active-high, evaluated on the clk rising edge:
  - seg_d (segclk delay register) <= 1, so no false edge if segclk is high at release.
  - idx <= DIGITS-1; started <= 0; shadow registers <= 0.
  - All outputs deasserted: an all inactive, seg all inactive, dp_n inactive. With ACTIVE_LOW=1 this is an=1111, seg=7'h7F, dp_n=1.
- Edge detect: tick = segclk & ~seg_d, with seg_d <= segclk every cycle. Exactly one tick per segclk rising edge. A held-high segclk produces no ticks.
- On tick:
  - idx <= (idx == DIGITS-1) ? 0 : idx+1. Wraps after DIGITS ticks; no other wrap values.
  - When the next idx is 0, snapshot value, dp and blank into the shadow registers and set started <= 1.
  - The first tick after reset therefore shows digit 0 from a fresh snapshot.
- Inputs that change mid-frame are not displayed until the next wrap to digit 0. Changes between snapshots are invisible.
- Outputs are registered and update in the clk cycle after the tick cycle, i.e. 1 clk of latency from the segclk rise being sampled. Outputs hold constant between ticks.
- Output for current idx i, active-high sense before ACTIVE_LOW inversion:
  - an: one-hot bit i.
  - seg: hex decode of shadow nibble i.
  - dp_n: shadow dp[i].
- If shadow blank[i] = 1, or started = 0: an, seg and dp all inactive. The digit is dark and its anode is off.
- Hex decode, active-low sense with ACTIVE_LOW=1, {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- No combinational path from any input to any output.
- Reset asserted mid-frame: outputs go dark on the next clk edge and scanning restarts per the reset rules. No partial digit may be emitted.
- Exactly one anode is active at any time, or none; two active anodes is a failure.

Test Plan:
- Reset, segclk held low for 100 clk -> an=1111, seg=7F, dp_n=1 throughout; no tick.
- Release rst with segclk already high -> no tick until segclk falls and rises again; outputs stay dark.
- value=16'h1234, dp=0, blank=0, 4 segclk pulses -> (an,seg) sequence (1110,19), (1101,30), (1011,24), (0111,79), each appearing 1 clk after its rise.
- Change value to 16'hABCD after the digit-1 tick -> digits 2 and 3 still show 2 and 1. After the wrap, digit 0 shows 21 (d), then 46 (C), 03 (b), 08 (A).
- dp=4'b0100, blank=4'b1000 -> dp_n=0 only while an=1011; during idx 3, an=1111 and seg=7F.
- Assert rst while idx=2 -> next clk: all outputs dark, idx=3. The first subsequent tick shows digit 0 (an=1110) from a new snapshot.
- Rerun the digit-sequence test with ACTIVE_LOW=0 -> all an, seg and dp_n values are the bitwise inverses of the ACTIVE_LOW=1 run.
